fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and default constants for the instruction fetch
//            controller: FSM state encoding, default reset PC, default halt
//            instruction encoding and wait-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_VALID  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [7:0]  c_reset_pc_default  = 8'h00;
  localparam logic [31:0] c_halt_word_default = 32'hFFFF_FFFF;

  // Wide enough for the largest legal WAIT_CYCLES (15).
  localparam int          c_wait_cnt_w        = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Purpose  : Instruction fetch sequencer. Presents pc to instruction memory,
//            waits WAIT_CYCLES cycles, captures the returned word into instr
//            and holds it (instr_valid) until the consumer acknowledges it.
//            Supports branch redirects and stops permanently on HALT_WORD.
// Ports    : clk, reset (sync, active-high)
//            fetch_req, branch_valid, branch_target, instr_ack, read_data (in)
//            inst_address, instr, instr_valid, pc, halted, fetch_count (out)
// Config   : FETCH_PERF_CNT_EN - when defined, fetch_count counts accepted
//            instructions (saturating); otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = 8,
  parameter int                 DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC    = ADDR_W'(c_reset_pc_default),
  parameter int                 WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0]  HALT_WORD   = DATA_W'(c_halt_word_default)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              instr_ack,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] inst_address,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [c_wait_cnt_w-1:0] c_wait_reload = c_wait_cnt_w'(WAIT_CYCLES - 1);

  fetch_state_t            r_state;
  logic [ADDR_W-1:0]       r_pc;
  logic [DATA_W-1:0]       r_instr;
  logic                    r_instr_valid;
  logic                    r_halted;
  logic [c_wait_cnt_w-1:0] r_wait_cnt;

  logic                    w_accept;
  logic [ADDR_W-1:0]       w_seq_pc;

  assign w_accept = (r_state == ST_VALID) && instr_ack;
  // Natural width wrap gives the modulo-2^ADDR_W increment.
  assign w_seq_pc = r_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A branch arriving with the request redirects the fetch itself.
          if (branch_valid) begin
            r_pc <= branch_target;
          end
          if (fetch_req) begin
            r_state    <= ST_ADDR;
            r_wait_cnt <= c_wait_reload;
          end
        end

        ST_ADDR: begin
          if (branch_valid) begin
            // Abort the in-flight read and restart the wait on the new address.
            r_pc       <= branch_target;
            r_wait_cnt <= c_wait_reload;
          end else if (r_wait_cnt == '0) begin
            r_instr       <= read_data;
            r_instr_valid <= 1'b1;
            r_state       <= ST_VALID;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end

        ST_VALID: begin
          // Without an ack everything holds, including against branches.
          if (instr_ack) begin
            r_instr_valid <= 1'b0;
            if (r_instr == HALT_WORD) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_pc <= branch_valid ? branch_target : w_seq_pc;
              if (fetch_req) begin
                r_state    <= ST_ADDR;
                r_wait_cnt <= c_wait_reload;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
        end

        ST_HALTED: begin
          r_halted      <= 1'b1;
          r_instr_valid <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 16'h0000;
    end else if (w_accept && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'h0001;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 16'h0000;
`endif

  assign inst_address = r_pc;
  assign pc           = r_pc;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign halted       = r_halted;

endmodule : fetch_controller
`default_nettype wire
